// File: rtl/fixed_p_std_sdiv_pipe.sv
// Multi-cycle signed fixed-point divider (restoring, one quotient bit per cycle)
// behind a go/done handshake; result is left/right in Q(INT_WIDTH.FRACT_WIDTH).
module fixed_p_std_sdiv_pipe #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  // Dividend |left| << FRACT_WIDTH spans WIDTH + FRACT_WIDTH bits (WIDTH = INT_WIDTH + FRACT_WIDTH).
  localparam int N  = INT_WIDTH + 2 * FRACT_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     dq_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] left_r;
  logic             rneg_r;
  logic             dz_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             done_r;

  logic [WIDTH-1:0] low_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s;

  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // The most negative value maps to 2^(WIDTH-1), which is exact as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg_val(v) : v;
  endfunction

  // Trial subtraction: remainder stays below the divisor, so a set MSB of the
  // shifted remainder alone proves it exceeds the divisor.
  always_comb begin
    low_s      = {rem_r[WIDTH-2:0], dq_r[N-1]};
    ge_s       = rem_r[WIDTH-1] | (low_s >= dvs_r);
    rem_next_s = low_s;
    if (ge_s) begin
      rem_next_s = low_s - dvs_r;
    end else begin
      rem_next_s = low_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (go) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(1)) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, shift/subtract iterations and sign fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= CW'(0);
      dq_r        <= N'(0);
      rem_r       <= WIDTH'(0);
      dvs_r       <= WIDTH'(0);
      left_r      <= WIDTH'(0);
      rneg_r      <= 1'b0;
      dz_r        <= 1'b0;
      quotient_r  <= WIDTH'(0);
      remainder_r <= WIDTH'(0);
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (go) begin
            left_r <= left;
            dvs_r  <= abs_val(right);
            rneg_r <= right[WIDTH-1];
            dz_r   <= (right == WIDTH'(0));
            dq_r   <= {abs_val(left), FRACT_WIDTH'(0)};
            rem_r  <= WIDTH'(0);
            cnt_r  <= CW'(N);
          end
        end
        RUN: begin
          rem_r <= rem_next_s;
          dq_r  <= {dq_r[N-2:0], ge_s};
          cnt_r <= cnt_r - CW'(1);
        end
        FIX: begin
          if (dz_r) begin
            quotient_r  <= left_r[WIDTH-1] ? Q_MIN : Q_MAX;
            remainder_r <= left_r;
          end else begin
            // Low bits of -Q equal -(low bits of Q); negating zero yields zero.
            quotient_r  <= (left_r[WIDTH-1] ^ rneg_r) ? neg_val(dq_r[WIDTH-1:0])
                                                      : dq_r[WIDTH-1:0];
            remainder_r <= left_r[WIDTH-1] ? neg_val(rem_r) : rem_r;
          end
        end
        DONE:    ;
        default: ;
      endcase
      done_r <= (state_r == FIX);
    end
  end

  assign out_quotient  = quotient_r;
  assign out_remainder = remainder_r;
  assign done          = done_r;

endmodule
